fft_twiddle_gen: RTL and testbench
==================================

FFT_TWIDDLE_GEN -- requirements
Module: fft_twiddle_gen

Interface
REQ-001 Parameter N_LOG2, default 5, log2 of FFT size N (N = 2^N_LOG2, N_LOG2 >= 3).
REQ-002 Parameter DATA_W, default 16, signed twiddle component width; unity scale = 2^(DATA_W-2).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  direct twiddle request valid.
REQ-006 in_ready  output  1  direct request accepted when in_valid && in_ready.
REQ-007 in_k  input  N_LOG2-1  twiddle index k, 0..N/2-1.
REQ-008 seq_start  input  1  single-cycle pulse: start auto-sequence for one stage.
REQ-009 seq_stage  input  clog2(N_LOG2)  radix-2 stage number s, 0..N_LOG2-1.
REQ-010 seq_busy  output  1  auto-sequence in progress.
REQ-011 out_valid  output  1  twiddle output valid.
REQ-012 out_ready  input  1  downstream accepts output.
REQ-013 out_re / out_im  output  DATA_W each  W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), two's complement.
REQ-014 out_last  output  1  marks final twiddle of an auto-sequence; 0 for direct requests.

Function
REQ-015 Storage SHALL be one quarter-wave cosine table C[i] = round(cos(2*pi*i/N) * 2^(DATA_W-2)), i = 0..N/4, registered read.
REQ-016 Fold: k <= N/4 -> re = C[k], im = -C[N/4-k]; k > N/4, m = k-N/4 -> re = -C[N/4-m], im = -C[m].
REQ-017 Negation SHALL be exact; no overflow possible since |C| <= 2^(DATA_W-2).
REQ-018 Pipeline: 2 stages (table read, fold/negate); accepted request appears on outputs 2 cycles later absent stall.
REQ-019 Advance enable en = !out_valid || out_ready; both stages move only when en=1; outputs hold stable while out_valid && !out_ready.
REQ-020 in_ready = en && !seq_busy; in_valid while seq_busy SHALL be ignored (not accepted).
REQ-021 Sequencer FSM states IDLE, RUN; IDLE --seq_start--> RUN; RUN --last index issued into pipeline--> IDLE.
REQ-022 In RUN, on each en cycle issue k = j * 2^(N_LOG2-1-s), j = 0..2^s-1, in ascending j; seq_stage sampled at seq_start.
REQ-023 seq_stage >= N_LOG2 SHALL be treated as N_LOG2-1.
REQ-024 seq_start while seq_busy SHALL be ignored; seq_start and in_valid in same IDLE cycle: sequencer wins, direct request not accepted.
REQ-025 seq_busy = 1 from cycle after seq_start through cycle last index enters pipeline.
REQ-026 out_last SHALL accompany the j = 2^s-1 output only; stage 0 yields one output (k=0) with out_last=1.
REQ-027 No outputs created or dropped under any out_ready pattern; order preserved.

Reset
REQ-028 rst_n low SHALL asynchronously clear: FSM to IDLE, j counter, pipeline valid bits, out_valid=0, out_last=0, out_re=0, out_im=0, seq_busy=0.
REQ-029 Reset mid-sequence SHALL discard in-flight twiddles; no output after release until a new request.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-031 Shared package holds FSM state typedef, default N_LOG2/DATA_W, and table-generation function (cosine scaling).
REQ-032 One sub-module fft_twiddle_qrom (quarter-wave table, registered read, parametrised by N_LOG2/DATA_W); fold, pipeline and sequencer in top.

Verification (N_LOG2=5, DATA_W=16)
REQ-033 Direct k=0,4,8,12, out_ready=1 -> (re,im) = (4000,0000), (2D41,D2BF), (0000,C000), (D2BF,D2BF) hex, each 2 cycles after acceptance.
REQ-034 seq_start, seq_stage=2 -> k=0,4,8,12 outputs back-to-back, out_last only on 4th, seq_busy low afterwards.
REQ-035 seq_stage=0 -> single output (4000,0000) with out_last=1; seq_stage=7 -> behaves as stage 4, 16 outputs.
REQ-036 Stage-4 sequence with out_ready random 50% -> all 16 twiddles in order, outputs stable while stalled, in_ready=0 throughout.
REQ-037 rst_n asserted mid stage-3 sequence -> outputs cleared immediately; after release no output; new direct k=1 -> (3EC5,F384).
REQ-038 Exhaustive sweep k=0..15 against reference cos/sin model -> exact match.

Source files
------------

// File: rtl/fft_twiddle_gen_pkg.sv
// rtl/fft_twiddle_gen_pkg.sv - shared types, defaults and cosine table generator for the twiddle generator
package fft_twiddle_gen_pkg;

    localparam int  DEFAULT_N_LOG2 = 5;
    localparam int  DEFAULT_DATA_W = 16;
    localparam real TWO_PI         = 6.283185307179586;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_t;

    // round(cos(2*pi*i/N) * 2^(data_w-2)); only called for the first quarter wave,
    // where the cosine is non-negative, so round-half-up equals round-half-away.
    function automatic int cos_entry(input int i, input int n_log2, input int data_w);
        real angle;
        real scaled;
        angle  = TWO_PI * real'(i) / real'(2 ** n_log2);
        scaled = $cos(angle) * real'(2 ** (data_w - 2));
        if (scaled >= 0.0) begin
            return $rtoi(scaled + 0.5);
        end
        return -$rtoi(-scaled + 0.5);
    endfunction

endpackage

// File: rtl/fft_twiddle_qrom.sv
// rtl/fft_twiddle_qrom.sv - quarter-wave cosine table with two registered read ports
module fft_twiddle_qrom
    import fft_twiddle_gen_pkg::*;
#(
    parameter int N_LOG2 = DEFAULT_N_LOG2,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_LOG2-2:0] addr_a,
    input  logic [N_LOG2-2:0] addr_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b
);

    localparam int AW = N_LOG2 - 1;
    localparam int QN = 2 ** (N_LOG2 - 2);

    logic [DATA_W-1:0] table_c [QN+1];
    logic [DATA_W-1:0] data_a_d, data_a_q;
    logic [DATA_W-1:0] data_b_d, data_b_q;

    // Entries 0..N/4 inclusive; the N/4 entry is needed for the fold's end points.
    for (genvar i = 0; i <= QN; i++) begin : g_entry
        assign table_c[i] = DATA_W'(cos_entry(i, N_LOG2, DATA_W));
    end

    // Table lookup; the fold never produces an address above N/4, guard anyway.
    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (en) begin
            data_a_d = (addr_a <= AW'(QN)) ? table_c[addr_a] : '0;
            data_b_d = (addr_b <= AW'(QN)) ? table_c[addr_b] : '0;
        end
    end

    // Read registers, frozen together with the rest of the pipeline when stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign data_a = data_a_q;
    assign data_b = data_b_q;

endmodule

// File: rtl/fft_twiddle_gen.sv
// rtl/fft_twiddle_gen.sv - radix-2 FFT twiddle generator: direct requests plus per-stage auto-sequence
module fft_twiddle_gen
    import fft_twiddle_gen_pkg::*;
#(
    parameter int N_LOG2 = DEFAULT_N_LOG2,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_LOG2-2:0]         in_k,
    input  logic                      seq_start,
    input  logic [$clog2(N_LOG2)-1:0] seq_stage,
    output logic                      seq_busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_re,
    output logic [DATA_W-1:0]         out_im,
    output logic                      out_last
);

    localparam int KW = N_LOG2 - 1;
    localparam int SW = $clog2(N_LOG2);
    localparam logic [KW-1:0] K_QUARTER = KW'(1) << (KW - 1);

    seq_state_t  state_q, state_d;
    logic [KW-1:0] j_q, j_d;
    logic [SW-1:0] shift_q, shift_d;

    logic          v1_q, v1_d;
    logic          hi1_q, hi1_d;
    logic          last1_q, last1_d;

    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_re_q, out_re_d;
    logic [DATA_W-1:0] out_im_q, out_im_d;

    logic              en;
    logic              busy;
    logic [SW:0]       stage_ext, stage_eff;
    logic [SW-1:0]     shift_new;
    logic [KW-1:0]     seq_k;
    logic              seq_last;
    logic              issue_valid;
    logic [KW-1:0]     issue_k;
    logic              issue_hi;
    logic [KW-1:0]     addr_a, addr_b;
    logic [DATA_W-1:0] rom_a, rom_b;

    // Handshake, sequencer index generation and quarter-wave address fold.
    always_comb begin
        en        = !out_valid_q || out_ready;
        busy      = (state_q == SEQ_RUN);
        // A simultaneous seq_start takes priority, so the direct request is refused.
        in_ready  = en && !busy && !seq_start;
        stage_ext = {1'b0, seq_stage};
        stage_eff = (stage_ext >= (SW+1)'(N_LOG2)) ? (SW+1)'(N_LOG2 - 1) : stage_ext;
        shift_new = SW'((SW+1)'(N_LOG2 - 1) - stage_eff);
        seq_k     = j_q << shift_q;
        seq_last  = (j_q == ({KW{1'b1}} >> shift_q));
        issue_valid = busy ? en : (in_valid && in_ready);
        issue_k     = busy ? seq_k : in_k;
        issue_hi    = (issue_k > K_QUARTER);
        // Second quadrant: re uses C[N/4-m] = C[N/2-k]; N/2 = 2^KW so it is just -k.
        addr_a = issue_hi ? (KW'(0) - issue_k) : issue_k;
        addr_b = issue_hi ? (issue_k - K_QUARTER) : (K_QUARTER - issue_k);
    end

    // Sequencer next state: latch the clamped stage on start, step j on each advance.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        shift_d = shift_q;
        case (state_q)
            SEQ_IDLE: begin
                if (seq_start) begin
                    state_d = SEQ_RUN;
                    j_d     = '0;
                    shift_d = shift_new;
                end
            end
            SEQ_RUN: begin
                if (en) begin
                    if (seq_last) begin
                        state_d = SEQ_IDLE;
                    end else begin
                        j_d = j_q + KW'(1);
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            j_q     <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            shift_q <= shift_d;
        end
    end

    fft_twiddle_qrom #(
        .N_LOG2(N_LOG2),
        .DATA_W(DATA_W)
    ) u_qrom (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .data_a (rom_a),
        .data_b (rom_b)
    );

    // Pipeline next state: stage 1 tags the table read, stage 2 applies the sign fold.
    always_comb begin
        v1_d        = v1_q;
        hi1_d       = hi1_q;
        last1_d     = last1_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        if (en) begin
            v1_d        = issue_valid;
            hi1_d       = issue_hi;
            last1_d     = busy && seq_last;
            out_valid_d = v1_q;
            out_last_d  = v1_q && last1_q;
            out_re_d    = hi1_q ? -rom_a : rom_a;
            out_im_d    = -rom_b;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            hi1_q       <= 1'b0;
            last1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            v1_q        <= v1_d;
            hi1_q       <= hi1_d;
            last1_q     <= last1_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign seq_busy  = busy;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// tb/tb_fft_twiddle_gen.sv - self-checking bench for fft_twiddle_gen with a cos/sin reference model
module tb_fft_twiddle_gen;

    localparam int  N_LOG2 = 5;
    localparam int  DATA_W = 16;
    localparam int  N      = 32;
    localparam int  KW     = 4;
    localparam int  SW     = 3;
    localparam real SCALE  = 16384.0;
    localparam real TWOPI  = 6.283185307179586;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [KW-1:0]     in_k      = '0;
    logic              seq_start = 1'b0;
    logic [SW-1:0]     seq_stage = '0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              seq_busy;
    logic              out_valid;
    logic              out_last;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [2*DATA_W:0] exp_q[$];
    int                xfer_cyc[$];
    logic              held = 1'b0;
    logic [2*DATA_W:0] held_val = '0;

    fft_twiddle_gen #(
        .N_LOG2(N_LOG2),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_k      (in_k),
        .seq_start (seq_start),
        .seq_stage (seq_stage),
        .seq_busy  (seq_busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int rnd_sym(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    // W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), scaled and rounded symmetrically.
    function automatic logic [2*DATA_W:0] ref_twiddle(input int k, input bit last);
        real ang;
        logic [DATA_W-1:0] re_v;
        logic [DATA_W-1:0] im_v;
        ang  = TWOPI * real'(k) / real'(N);
        re_v = DATA_W'(rnd_sym($cos(ang) * SCALE));
        im_v = DATA_W'(-rnd_sym($sin(ang) * SCALE));
        return {re_v, im_v, last};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int stage);
        int s_eff;
        int cnt;
        s_eff = (stage >= N_LOG2) ? N_LOG2 - 1 : stage;
        cnt   = 1 << s_eff;
        for (int j = 0; j < cnt; j++) begin
            exp_q.push_back(ref_twiddle(j * (1 << (N_LOG2 - 1 - s_eff)), j == cnt - 1));
        end
    endtask

    task automatic start_seq(input int stage);
        seq_stage = SW'(stage);
        seq_start = 1'b1;
        push_seq(stage);
        step();
        seq_start = 1'b0;
        check("seq_busy_after_start", 64'(seq_busy), 64'(1));
    endtask

    task automatic drain(input bit rnd_ready, input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || seq_busy || out_valid) && n < 400) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = seq_busy ? 1'($urandom_range(0, 1)) : 1'b0;
            in_k      = KW'($urandom_range(0, 15));
            #1;
            if (seq_busy) check({tag, "_in_ready_busy"}, 64'(in_ready), 64'(0));
            step();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_busy_low"}, 64'(seq_busy), 64'(0));
    endtask

    task automatic send_direct(input int k, input bit rnd_ready);
        int  n;
        bit  accepted;
        n        = 0;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_k     = KW'(k);
        while (!accepted && n < 100) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_ready) begin
                exp_q.push_back(ref_twiddle(k, 1'b0));
                accepted = 1'b1;
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        check("direct_accepted", 64'(accepted), 64'(1));
    endtask

    // Output scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid_hold", 64'(out_valid), 64'(1));
                check("stall_data_hold", 64'({out_re, out_im, out_last}), 64'(held_val));
            end
            if (out_valid && out_ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'({out_re, out_im, out_last}), 64'(0));
                    check("unexpected_output_valid", 64'(out_valid), 64'(0));
                end else begin
                    check("twiddle", 64'({out_re, out_im, out_last}), 64'(exp_q.pop_front()));
                end
                held = 1'b0;
            end else if (out_valid) begin
                held     = 1'b1;
                held_val = {out_re, out_im, out_last};
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          d_k[4];
        logic [31:0] d_exp[4];
        d_k   = '{0, 4, 8, 12};
        d_exp = '{32'h4000_0000, 32'h2D41_D2BF, 32'h0000_C000, 32'hD2BF_D2BF};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_seq_busy", 64'(seq_busy), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_data", 64'({out_re, out_im}), 64'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("in_ready_after_release", 64'(in_ready), 64'(1));

        // Direct requests with fixed two-cycle latency
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_k     = KW'(d_k[i]);
            exp_q.push_back(ref_twiddle(d_k[i], 1'b0));
            step();
            in_valid = 1'b0;
            check("direct_lat1_not_valid", 64'(out_valid), 64'(0));
            step();
            check("direct_lat2_valid", 64'(out_valid), 64'(1));
            check("direct_value", 64'({out_re, out_im}), 64'(d_exp[i]));
            check("direct_last_zero", 64'(out_last), 64'(0));
        end
        drain(1'b0, "direct");

        // Stage 2: four back-to-back outputs
        xfer_cyc.delete();
        start_seq(2);
        drain(1'b0, "stage2");
        check("stage2_count", 64'(xfer_cyc.size()), 64'(4));
        if (xfer_cyc.size() == 4)
            check("stage2_back_to_back", 64'(xfer_cyc[3] - xfer_cyc[0]), 64'(3));

        // Stage 0: single output with last
        xfer_cyc.delete();
        start_seq(0);
        drain(1'b0, "stage0");
        check("stage0_count", 64'(xfer_cyc.size()), 64'(1));

        // Stage 7 clamps to stage 4
        xfer_cyc.delete();
        start_seq(7);
        drain(1'b0, "stage7");
        check("stage7_count", 64'(xfer_cyc.size()), 64'(16));

        // seq_start and in_valid together: only the sequence runs
        seq_stage = SW'(1);
        seq_start = 1'b1;
        in_valid  = 1'b1;
        in_k      = KW'(5);
        push_seq(1);
        #1;
        check("combo_in_ready", 64'(in_ready), 64'(0));
        step();
        seq_start = 1'b0;
        in_valid  = 1'b0;
        drain(1'b0, "combo");

        // seq_start while busy is ignored
        start_seq(2);
        seq_stage = SW'(4);
        seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        drain(1'b0, "restart_ignored");

        // Stage 4 under random backpressure
        xfer_cyc.delete();
        start_seq(4);
        drain(1'b1, "stage4_rand");
        check("stage4_rand_count", 64'(xfer_cyc.size()), 64'(16));

        // Reset in the middle of a stage-3 sequence
        start_seq(3);
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_data", 64'({out_re, out_im, out_last}), 64'(0));
        check("midrst_seq_busy", 64'(seq_busy), 64'(0));
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) step();
        check("post_rst_idle", 64'(out_valid), 64'(0));
        in_valid = 1'b1;
        in_k     = KW'(1);
        exp_q.push_back(ref_twiddle(1, 1'b0));
        step();
        in_valid = 1'b0;
        step();
        check("post_rst_k1", 64'({out_re, out_im, out_valid}), 64'({32'h3EC5_F384, 1'b1}));
        drain(1'b0, "post_rst");

        // Exhaustive sweep of k against the model
        for (int k = 0; k < 16; k++) send_direct(k, 1'b0);
        drain(1'b0, "sweep");

        // Random k under random backpressure
        for (int i = 0; i < 30; i++) send_direct(int'($urandom_range(0, 15)), 1'b1);
        drain(1'b1, "random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
